// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: control bundle
// layout and the default payload width of each stage boundary.
package pipe_pkg;

    // Control bundle width and bit positions inside the bundle
    localparam int PIPE_CTRL_W    = 10;
    localparam int CTRL_MEMWRITE  = 0;
    localparam int CTRL_MEMREAD   = 1;
    localparam int CTRL_REGWRITE  = 2;
    localparam int CTRL_ALUOP_LSB = 3;
    localparam int CTRL_ALUOP_W   = 4;
    localparam int CTRL_ALUSRC    = 7;
    localparam int CTRL_BRANCH    = 8;
    localparam int CTRL_MEMTOREG  = 9;

    // Default payload widths per stage boundary
    localparam int ID_EX_DATA_W  = 160;
    localparam int EX_MEM_DATA_W = 112;
    localparam int MEM_WB_DATA_W = 72;

    typedef enum logic [1:0] {
        STG_ID_EX  = 2'd0,
        STG_EX_MEM = 2'd1,
        STG_MEM_WB = 2'd2
    } pipe_stage_e;

    // Payload width for a given stage boundary
    function automatic int stage_data_w(pipe_stage_e stg);
        case (stg)
            STG_ID_EX:  return ID_EX_DATA_W;
            STG_EX_MEM: return EX_MEM_DATA_W;
            default:    return MEM_WB_DATA_W;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_hold_limiter.sv
// Bounds how long a stall may freeze the stage, flags forced advances and
// counts honoured stall cycles with saturation.
module hold_limiter #(
    parameter int MAX_HOLD = 1,
    parameter int HCNT_W   = 4,
    parameter int STAT_W   = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              advance_o,
    output logic              hold_forced_o,
    output logic [STAT_W-1:0] stall_cnt_o
);

    logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              hold_forced_q, hold_forced_d;
    logic              limit;

    // With MAX_HOLD=0 the counter never leaves 0, so limit stays asserted
    assign limit     = (hold_cnt_q == HCNT_W'(MAX_HOLD));
    assign advance_o = !hold_i || limit;

    // Next-state: flush clears the hold run, advance restarts it, a held
    // cycle extends it and bumps the statistics counter
    always_comb begin
        hold_cnt_d    = hold_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        hold_forced_d = 1'b0;
        if (flush_i) begin
            hold_cnt_d = '0;
        end else if (advance_o) begin
            hold_cnt_d    = '0;
            hold_forced_d = hold_i && limit;
        end else begin
            hold_cnt_d  = hold_cnt_q + HCNT_W'(1);
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + STAT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            hold_forced_q <= 1'b0;
        end else begin
            hold_cnt_q    <= hold_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            hold_forced_q <= hold_forced_d;
        end
    end

    assign hold_forced_o = hold_forced_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload + control bundle with valid bit,
// bounded stall, flush/bubble insertion and stall statistics.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = ID_EX_DATA_W,
    parameter int CTRL_W   = PIPE_CTRL_W,
    parameter int MAX_HOLD = 1,
    parameter int HCNT_W   = 4,
    parameter int STAT_W   = 16,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              hold_forced,
    output logic [STAT_W-1:0] stall_cnt
);

    logic              advance;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    hold_limiter #(
        .MAX_HOLD (MAX_HOLD),
        .HCNT_W   (HCNT_W),
        .STAT_W   (STAT_W)
    ) u_hold_limiter (
        .clk_i         (clk),
        .reset_i       (reset),
        .hold_i        (hold),
        .flush_i       (flush),
        .advance_o     (advance),
        .hold_forced_o (hold_forced),
        .stall_cnt_o   (stall_cnt)
    );

    assign in_ready = advance;

    // Payload mux: flush inserts a bubble, advance captures upstream, else hold.
    // Control is gated to zero for any invalid slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLR_DATA) data_d = '0;
        end else if (advance) begin
            valid_d = in_valid;
            data_d  = in_data;
            ctrl_d  = in_valid ? in_ctrl : '0;
        end
    end

    // Register bank with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ctrl  = ctrl_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Two stage-register instances sharing one stimulus stream:
//   k=0: MAX_HOLD=3, STAT_W=4,  CLR_DATA=0
//   k=1: MAX_HOLD=0, STAT_W=16, CLR_DATA=1
module tb_pipe_stage_reg;

    localparam int DW = 64;
    localparam int CW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, hold, flush, in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic [1:0]         d_ready, d_valid, d_hf;
    logic [1:0][DW-1:0] d_data;
    logic [1:0][CW-1:0] d_ctrl;
    logic [3:0]         a_stall;
    logic [15:0]        b_stall;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .MAX_HOLD(3), .HCNT_W(4),
                     .STAT_W(4), .CLR_DATA(1'b0)) u_a (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_ready(d_ready[0]), .out_valid(d_valid[0]), .out_data(d_data[0]),
        .out_ctrl(d_ctrl[0]), .hold_forced(d_hf[0]), .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .MAX_HOLD(0), .HCNT_W(4),
                     .STAT_W(16), .CLR_DATA(1'b1)) u_b (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_ready(d_ready[1]), .out_valid(d_valid[1]), .out_data(d_data[1]),
        .out_ctrl(d_ctrl[1]), .hold_forced(d_hf[1]), .stall_cnt(b_stall)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural reference: per instance, the architectural state and the
    // number of consecutive cycles the current hold run has frozen the stage
    int            mh[2]     = '{3, 0};
    int            smax[2]   = '{15, 65535};
    bit            clr[2]    = '{1'b0, 1'b1};
    bit            m_valid[2];
    logic [DW-1:0] m_data[2];
    logic [CW-1:0] m_ctrl[2];
    bit            m_hf[2];
    int            m_stall[2];
    int            m_run[2];

    function automatic int dstall(int k);
        return (k == 0) ? int'(a_stall) : int'(b_stall);
    endfunction

    function automatic bit exp_ready(int k);
        return !hold || (m_run[k] >= mh[k]);
    endfunction

    // One clock edge: advance the reference with the inputs seen at the edge
    task automatic step();
        bit adv;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            adv = exp_ready(k);
            if (reset) begin
                m_valid[k] = 0; m_data[k] = '0; m_ctrl[k] = '0;
                m_hf[k] = 0; m_stall[k] = 0; m_run[k] = 0;
            end else if (flush) begin
                m_valid[k] = 0; m_ctrl[k] = '0;
                if (clr[k]) m_data[k] = '0;
                m_hf[k] = 0; m_run[k] = 0;
            end else if (adv) begin
                m_valid[k] = in_valid;
                m_data[k]  = in_data;
                m_ctrl[k]  = in_valid ? in_ctrl : '0;
                m_hf[k]    = hold;
                m_run[k]   = 0;
            end else begin
                m_hf[k]  = 0;
                m_run[k] = m_run[k] + 1;
                if (m_stall[k] < smax[k]) m_stall[k] = m_stall[k] + 1;
            end
        end
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        reset = 1; hold = 1; flush = 1; in_valid = 1;
        in_data = rnd_data(); in_ctrl = CW'($urandom());
        step();
        in_data = rnd_data(); in_ctrl = CW'($urandom()); hold = 0; flush = 0;
        step();
        reset = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp += 5;
            if (d_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got %b want 0", k, d_valid[k]); end
            if (d_data[k] !== '0) begin n_fail++; $display("FAIL reset_data[%0d] got %h want 0", k, d_data[k]); end
            if (d_ctrl[k] !== '0) begin n_fail++; $display("FAIL reset_ctrl[%0d] got %h want 0", k, d_ctrl[k]); end
            if (d_hf[k] !== 1'b0 || dstall(k) != 0) begin n_fail++; $display("FAIL reset_stat[%0d] got hf=%b stall=%0d want 0/0", k, d_hf[k], dstall(k)); end
            if (d_ready[k] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d] got %b want 1", k, d_ready[k]); end
        end
    endtask

    task automatic test_pass_through();
        hold = 0; flush = 0; in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] d;
            logic [CW-1:0] c;
            d = {8{8'hA5}} ^ DW'(i * 32'h0101_0101);
            c = CW'($urandom());
            in_data = d; in_ctrl = c;
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp += 3;
                if (d_data[k] !== d) begin n_fail++; $display("FAIL pass_data[%0d] got %h want %h", k, d_data[k], d); end
                if (d_ctrl[k] !== c || d_valid[k] !== 1'b1) begin n_fail++; $display("FAIL pass_ctrl[%0d] got %h/%b want %h/1", k, d_ctrl[k], d_valid[k], c); end
                if (dstall(k) != 0) begin n_fail++; $display("FAIL pass_stall[%0d] got %0d want 0", k, dstall(k)); end
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [DW-1:0] frozen, adv_data;
        frozen = d_data[0];
        adv_data = '0;
        hold = 1; flush = 0; in_valid = 1;
        for (int c = 1; c <= 6; c++) begin
            in_data = rnd_data(); in_ctrl = CW'($urandom());
            #1;
            n_cmp++;
            if (d_ready[0] !== (c == 4)) begin n_fail++; $display("FAIL hold_ready c%0d got %b want %b", c, d_ready[0], c == 4); end
            if (c == 4) adv_data = in_data;
            step();
            n_cmp += 3;
            if (d_data[0] !== ((c < 4) ? frozen : adv_data)) begin n_fail++; $display("FAIL hold_data c%0d got %h want %h", c, d_data[0], (c < 4) ? frozen : adv_data); end
            if (d_hf[0] !== (c == 4)) begin n_fail++; $display("FAIL hold_forced c%0d got %b want %b", c, d_hf[0], c == 4); end
            if (d_data[1] !== in_data || d_hf[1] !== 1'b1) begin n_fail++; $display("FAIL hold_b c%0d got %h/%b want %h/1", c, d_data[1], d_hf[1], in_data); end
        end
        n_cmp += 2;
        if (a_stall !== 4'd5) begin n_fail++; $display("FAIL hold_stall_a got %0d want 5", a_stall); end
        if (b_stall !== 16'd0) begin n_fail++; $display("FAIL hold_stall_b got %0d want 0", b_stall); end
    endtask

    task automatic test_flush_vs_hold();
        logic [DW-1:0] keep;
        keep = d_data[0];
        hold = 1; flush = 1; in_valid = 1; in_data = rnd_data(); in_ctrl = '1;
        step();
        n_cmp += 4;
        if (d_valid !== 2'b00 || d_ctrl[0] !== '0 || d_ctrl[1] !== '0) begin n_fail++; $display("FAIL flush_vc got v=%b c0=%h c1=%h want 0", d_valid, d_ctrl[0], d_ctrl[1]); end
        if (d_data[0] !== keep) begin n_fail++; $display("FAIL flush_keep got %h want %h", d_data[0], keep); end
        if (d_data[1] !== '0) begin n_fail++; $display("FAIL flush_clr got %h want 0", d_data[1]); end
        if (a_stall !== 4'd5 || d_hf !== 2'b00) begin n_fail++; $display("FAIL flush_stat got %0d/%b want 5/00", a_stall, d_hf); end
        // hold run must restart: 3 more frozen cycles before the forced advance
        flush = 0;
        for (int c = 1; c <= 4; c++) begin
            in_data = rnd_data();
            step();
        end
        n_cmp += 2;
        if (a_stall !== 4'd8) begin n_fail++; $display("FAIL flush_restart got %0d want 8", a_stall); end
        if (d_hf[0] !== 1'b1 || d_data[0] !== in_data) begin n_fail++; $display("FAIL flush_fadv got %b/%h want 1/%h", d_hf[0], d_data[0], in_data); end
    endtask

    task automatic test_bubble();
        hold = 0; flush = 0; in_valid = 0; in_ctrl = '1; in_data = rnd_data();
        step();
        for (int k = 0; k < 2; k++) begin
            n_cmp += 2;
            if (d_valid[k] !== 1'b0 || d_ctrl[k] !== '0) begin n_fail++; $display("FAIL bubble_vc[%0d] got %b/%h want 0/0", k, d_valid[k], d_ctrl[k]); end
            if (d_data[k] !== in_data) begin n_fail++; $display("FAIL bubble_data[%0d] got %h want %h", k, d_data[k], in_data); end
        end
    endtask

    task automatic test_saturation();
        hold = 1; flush = 0; in_valid = 1;
        for (int c = 0; c < 30; c++) begin
            in_data = rnd_data(); in_ctrl = CW'($urandom());
            step();
            n_cmp++;
            if (d_data[1] !== in_data) begin n_fail++; $display("FAIL mh0_adv c%0d got %h want %h", c, d_data[1], in_data); end
        end
        n_cmp += 2;
        if (a_stall !== 4'hF) begin n_fail++; $display("FAIL sat_a got %0d want 15", a_stall); end
        if (b_stall !== 16'd0) begin n_fail++; $display("FAIL mh0_stall got %0d want 0", b_stall); end
    endtask

    task automatic test_reset_mid_hold();
        hold = 1; flush = 0; in_valid = 1;
        in_data = rnd_data(); step();
        in_data = rnd_data(); step();
        reset = 1; step();
        reset = 0;
        for (int c = 1; c <= 4; c++) begin
            in_data = rnd_data();
            step();
            n_cmp++;
            if (d_valid[0] !== (c == 4) || d_hf[0] !== (c == 4)) begin n_fail++; $display("FAIL rst_hold c%0d got v=%b hf=%b want %b", c, d_valid[0], d_hf[0], c == 4); end
        end
        n_cmp++;
        if (a_stall !== 4'd3) begin n_fail++; $display("FAIL rst_hold_stall got %0d want 3", a_stall); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 99) < 2);
            hold     = ($urandom_range(0, 99) < 65);
            flush    = ($urandom_range(0, 99) < 8);
            in_valid = ($urandom_range(0, 99) < 75);
            in_data  = rnd_data();
            in_ctrl  = CW'($urandom());
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (d_ready[k] !== exp_ready(k)) begin n_fail++; $display("FAIL rnd_ready[%0d] c%0d got %b want %b", k, c, d_ready[k], exp_ready(k)); end
            end
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (d_valid[k] !== m_valid[k] || d_data[k] !== m_data[k] || d_ctrl[k] !== m_ctrl[k] ||
                    d_hf[k] !== m_hf[k] || dstall(k) != m_stall[k]) begin
                    n_fail++;
                    $display("FAIL rnd_state[%0d] c%0d got v=%b d=%h c=%h hf=%b s=%0d want v=%b d=%h c=%h hf=%b s=%0d",
                             k, c, d_valid[k], d_data[k], d_ctrl[k], d_hf[k], dstall(k),
                             m_valid[k], m_data[k], m_ctrl[k], m_hf[k], m_stall[k]);
                end
            end
        end
        reset = 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_data[k] = '0; m_ctrl[k] = '0;
            m_hf[k] = 0; m_stall[k] = 0; m_run[k] = 0;
        end
        reset = 1; hold = 0; flush = 0; in_valid = 0; in_data = '0; in_ctrl = '0;
        test_reset();
        test_pass_through();
        test_hold_limit();
        test_flush_vs_hold();
        test_bubble();
        test_saturation();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
